// File: rtl/loom_axil_req_engine.sv
// ---------------------------------------------------------------------------
// loom_axil_req_engine
//
// Turns host requests (valid/ready) into AXI-Lite reads or writes, with up to
// MAX_OUTSTANDING transactions in flight. It returns a tagged response for
// each request, in request order. It also collects interrupt rising edges
// into a handshaked event port, and provides a drain handshake for shutdown.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   req_*                     host request: write flag, addr, wdata, wstrb, id
//   rsp_*                     registered response: write flag, data, resp, id
//   m_axil_ar/r/aw/w/b*       AXI-Lite master channels
//   irq_i                     level interrupts
//   irq_valid_o/ready_i/bits  accumulated rising-edge event port
//   drain_req_i/drain_done_o  stop accepting, flush, then report done (sticky)
//   outstanding_o             accepted but not yet answered transactions
// ---------------------------------------------------------------------------
module loom_axil_req_engine #(
    parameter int ADDR_WIDTH      = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int N_IRQ           = 16,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8,
    localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // host request
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [STRB_WIDTH-1:0] req_wstrb_i,
    input  logic [ID_WIDTH-1:0]   req_id_i,
    // host response
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_write_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic [1:0]            rsp_resp_o,
    output logic [ID_WIDTH-1:0]   rsp_id_o,
    // AXI-Lite read address / data
    output logic [ADDR_WIDTH-1:0] m_axil_araddr_o,
    output logic                  m_axil_arvalid_o,
    input  logic                  m_axil_arready_i,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata_i,
    input  logic [1:0]            m_axil_rresp_i,
    input  logic                  m_axil_rvalid_i,
    output logic                  m_axil_rready_o,
    // AXI-Lite write address / data / response
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr_o,
    output logic                  m_axil_awvalid_o,
    input  logic                  m_axil_awready_i,
    output logic [DATA_WIDTH-1:0] m_axil_wdata_o,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb_o,
    output logic                  m_axil_wvalid_o,
    input  logic                  m_axil_wready_i,
    input  logic [1:0]            m_axil_bresp_i,
    input  logic                  m_axil_bvalid_i,
    output logic                  m_axil_bready_o,
    // interrupts
    input  logic [N_IRQ-1:0]      irq_i,
    output logic                  irq_valid_o,
    input  logic                  irq_ready_i,
    output logic [N_IRQ-1:0]      irq_bits_o,
    // drain
    input  logic                  drain_req_i,
    output logic                  drain_done_o,
    output logic [CNT_WIDTH-1:0]  outstanding_o
);

    localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } mode_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    mode_e                  mode_q;
    logic                   live_q;       // low only in the cycle(s) of reset
    logic                   drain_q;
    logic                   drain_done_q;
    logic [CNT_WIDTH-1:0]   outstanding_q;
    logic [PTR_WIDTH-1:0]   wr_ptr_q;
    logic [PTR_WIDTH-1:0]   rd_ptr_q;
    logic [ID_WIDTH:0]      fifo_mem [MAX_OUTSTANDING];   // {write, id}

    logic [ADDR_WIDTH-1:0]  araddr_q;
    logic                   arvalid_q;
    logic [ADDR_WIDTH-1:0]  awaddr_q;
    logic                   awvalid_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [STRB_WIDTH-1:0]  wstrb_q;
    logic                   wvalid_q;

    logic                   rsp_valid_q;
    logic                   rsp_write_q;
    logic [DATA_WIDTH-1:0]  rsp_data_q;
    logic [1:0]             rsp_resp_q;
    logic [ID_WIDTH-1:0]    rsp_id_q;

    logic [N_IRQ-1:0]       irq_prev_q;
    logic [N_IRQ-1:0]       pending_q;

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic                   read_slot_empty;
    logic                   write_slot_empty;
    logic                   slot_empty;
    logic                   dir_ok;
    logic                   accept;
    logic                   have_inflight;
    logic                   rsp_free;
    logic                   r_done;
    logic                   b_done;
    logic                   complete;
    logic [ID_WIDTH:0]      fifo_head;
    logic                   irq_clear;
    logic                   drain_cond;

    assign read_slot_empty  = !arvalid_q;
    assign write_slot_empty = !awvalid_q && !wvalid_q;
    assign slot_empty       = req_write_i ? write_slot_empty : read_slot_empty;
    // A direction change is only allowed once everything in flight has
    // answered; this is what keeps responses in request order.
    assign dir_ok           = (outstanding_q == '0) || (req_write_i == (mode_q == MODE_WRITE));
    assign req_ready_o      = live_q && !drain_q && slot_empty && dir_ok
                           && (outstanding_q < CNT_WIDTH'(MAX_OUTSTANDING));
    assign accept           = req_valid_i && req_ready_o;

    // Never take a beat that has no matching tag in the FIFO.
    assign have_inflight    = (outstanding_q != '0);
    assign rsp_free         = !rsp_valid_q || rsp_ready_i;
    assign m_axil_rready_o  = have_inflight && (mode_q == MODE_READ)  && rsp_free;
    assign m_axil_bready_o  = have_inflight && (mode_q == MODE_WRITE) && rsp_free;
    assign r_done           = m_axil_rvalid_i && m_axil_rready_o;
    assign b_done           = m_axil_bvalid_i && m_axil_bready_o;
    assign complete         = r_done || b_done;
    assign fifo_head        = fifo_mem[rd_ptr_q];

    assign irq_clear        = irq_valid_o && irq_ready_i;
    assign drain_cond       = drain_q && (outstanding_q == '0) && read_slot_empty
                           && write_slot_empty && !rsp_valid_q;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Tag FIFO storage (pointers live in the reset domain below)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_mem[wr_ptr_q] <= {req_write_i, req_id_i};
        end
    end

    // -----------------------------------------------------------------------
    // Main sequential logic
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q        <= MODE_READ;
            live_q        <= 1'b0;
            drain_q       <= 1'b0;
            drain_done_q  <= 1'b0;
            outstanding_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            araddr_q      <= '0;
            arvalid_q     <= 1'b0;
            awaddr_q      <= '0;
            awvalid_q     <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            wvalid_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_resp_q    <= '0;
            rsp_id_q      <= '0;
            irq_prev_q    <= '0;
            pending_q     <= '0;
        end else begin
            live_q <= 1'b1;

            // Request acceptance
            if (accept) begin
                mode_q   <= req_write_i ? MODE_WRITE : MODE_READ;
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end

            // Read address channel: slot is free again once AR handshakes
            if (accept && !req_write_i) begin
                arvalid_q <= 1'b1;
                araddr_q  <= req_addr_i;
            end else if (m_axil_arready_i) begin
                arvalid_q <= 1'b0;
            end

            // Write address and data channels complete independently
            if (accept && req_write_i) begin
                awvalid_q <= 1'b1;
                awaddr_q  <= req_addr_i;
                wvalid_q  <= 1'b1;
                wdata_q   <= req_wdata_i;
                wstrb_q   <= req_wstrb_i;
            end else begin
                if (m_axil_awready_i) awvalid_q <= 1'b0;
                if (m_axil_wready_i)  wvalid_q  <= 1'b0;
            end

            // In-flight count; simultaneous accept and completion cancel out
            case ({accept, complete})
                2'b10:   outstanding_q <= outstanding_q + CNT_WIDTH'(1);
                2'b01:   outstanding_q <= outstanding_q - CNT_WIDTH'(1);
                default: outstanding_q <= outstanding_q;
            endcase

            // Response register: a new beat may replace one consumed this cycle
            if (complete) begin
                rd_ptr_q    <= ptr_inc(rd_ptr_q);
                rsp_valid_q <= 1'b1;
                rsp_write_q <= fifo_head[ID_WIDTH];
                rsp_id_q    <= fifo_head[ID_WIDTH-1:0];
                rsp_data_q  <= r_done ? m_axil_rdata_i : '0;
                rsp_resp_q  <= r_done ? m_axil_rresp_i : m_axil_bresp_i;
            end else if (rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end

            // IRQ edges: a clear only removes what was presented, so edges
            // landing in the clear cycle are kept.
            irq_prev_q <= irq_i;
            pending_q  <= (pending_q & ~(irq_clear ? pending_q : '0)) | (irq_i & ~irq_prev_q);

            // Drain
            drain_q      <= drain_q | drain_req_i;
            drain_done_q <= drain_done_q | drain_cond;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign m_axil_araddr_o  = araddr_q;
    assign m_axil_arvalid_o = arvalid_q;
    assign m_axil_awaddr_o  = awaddr_q;
    assign m_axil_awvalid_o = awvalid_q;
    assign m_axil_wdata_o   = wdata_q;
    assign m_axil_wstrb_o   = wstrb_q;
    assign m_axil_wvalid_o  = wvalid_q;

    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_write_o      = rsp_write_q;
    assign rsp_data_o       = rsp_data_q;
    assign rsp_resp_o       = rsp_resp_q;
    assign rsp_id_o         = rsp_id_q;

    assign irq_valid_o      = |pending_q;
    assign irq_bits_o       = pending_q;

    assign drain_done_o     = drain_done_q | drain_cond;
    assign outstanding_o    = outstanding_q;

    // A response beat with nothing in flight means the slave is misbehaving.
    a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !((m_axil_rvalid_i || m_axil_bvalid_i) && (outstanding_q == '0)));

endmodule
